// File: rtl/cfg_frame_parser_if.sv
// rtl/cfg_frame_parser_if.sv - byte input and RAM-write/status output bundle of the config frame parser
interface cfg_frame_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] wr_data;
   logic [7:0] wr_addr;
   logic       wr_en;
   logic       pc_start;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   // Byte source side (UART receiver or testbench)
   modport master (
      output rx_data, rx_valid,
      input  wr_data, wr_addr, wr_en, pc_start, frame_err, err_code, busy
   );

   // Parser side
   modport slave (
      input  rx_data, rx_valid,
      output wr_data, wr_addr, wr_en, pc_start, frame_err, err_code, busy
   );
endinterface

// File: rtl/cfg_frame_parser.sv
// rtl/cfg_frame_parser.sv - HDR/LEN/payload/XOR frame parser writing channel RAM; optional CFG_BIT_REVERSE_EN
module cfg_frame_parser #(
   parameter logic [7:0] HDR     = 8'hA5,
   parameter int          LEN_MAX = 160,
   parameter int          TIMEOUT = 50000
) (
   input  logic               clk,
   input  logic               rst,
   cfg_frame_parser_if.slave  bus
);

   localparam int GW = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0] TIMEOUT_C = GW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, LEN, DATA, CHK} state_t;

   state_t        state, state_n;
   logic [7:0]    len_q, len_n;
   logic [7:0]    idx_q, idx_n;
   logic [7:0]    csum_q, csum_n;
   logic [GW-1:0] gap_q, gap_n;
   logic [7:0]    wr_data_q, wr_data_n;
   logic [7:0]    wr_addr_q, wr_addr_n;
   logic          wr_en_q, wr_en_n;
   logic          pc_start_q, pc_start_n;
   logic          frame_err_q, frame_err_n;
   logic [1:0]    err_code_q, err_code_n;
   logic [7:0]    rx_byte;
   logic          timeout;

`ifdef CFG_BIT_REVERSE_EN
   // Link delivers bytes MSB-first; mirror them before any interpretation
   assign rx_byte = {bus.rx_data[0], bus.rx_data[1], bus.rx_data[2], bus.rx_data[3],
                     bus.rx_data[4], bus.rx_data[5], bus.rx_data[6], bus.rx_data[7]};
`else
   assign rx_byte = bus.rx_data;
`endif

   // A byte in the same cycle as the gap limit wins over the timeout
   assign timeout = (state != IDLE) && !bus.rx_valid && (gap_q == TIMEOUT_C);

   // Next-state and next-register values; strobes default low each cycle
   always_comb begin
      state_n     = state;
      len_n       = len_q;
      idx_n       = idx_q;
      csum_n      = csum_q;
      gap_n       = gap_q;
      wr_data_n   = wr_data_q;
      wr_addr_n   = wr_addr_q;
      wr_en_n     = 1'b0;
      pc_start_n  = 1'b0;
      frame_err_n = 1'b0;
      err_code_n  = err_code_q;

      if (state != IDLE) begin
         if (bus.rx_valid)
            gap_n = '0;
         else if (!timeout)
            gap_n = gap_q + 1'b1;
      end

      if (timeout) begin
         frame_err_n = 1'b1;
         err_code_n  = 2'b11;
         gap_n       = '0;
         state_n     = IDLE;
      end else if (bus.rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_byte == HDR) begin
                  err_code_n = 2'b00;
                  csum_n     = 8'h00;
                  idx_n      = 8'h00;
                  gap_n      = '0;
                  state_n    = LEN;
               end
            end
            LEN: begin
               if (rx_byte == 8'h00 || int'(rx_byte) > LEN_MAX) begin
                  frame_err_n = 1'b1;
                  err_code_n  = 2'b01;
                  state_n     = IDLE;
               end else begin
                  len_n   = rx_byte;
                  csum_n  = csum_q ^ rx_byte;
                  state_n = DATA;
               end
            end
            DATA: begin
               wr_en_n   = 1'b1;
               wr_data_n = rx_byte;
               wr_addr_n = idx_q;
               csum_n    = csum_q ^ rx_byte;
               idx_n     = idx_q + 8'd1;
               if (idx_q == len_q - 8'd1)
                  state_n = CHK;
            end
            CHK: begin
               if (rx_byte == csum_q) begin
                  pc_start_n = 1'b1;
               end else begin
                  frame_err_n = 1'b1;
                  err_code_n  = 2'b10;
               end
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // State and datapath registers; reset discards any partial frame silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         len_q       <= 8'h00;
         idx_q       <= 8'h00;
         csum_q      <= 8'h00;
         gap_q       <= '0;
         wr_data_q   <= 8'h00;
         wr_addr_q   <= 8'h00;
         wr_en_q     <= 1'b0;
         pc_start_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'b00;
      end else begin
         state       <= state_n;
         len_q       <= len_n;
         idx_q       <= idx_n;
         csum_q      <= csum_n;
         gap_q       <= gap_n;
         wr_data_q   <= wr_data_n;
         wr_addr_q   <= wr_addr_n;
         wr_en_q     <= wr_en_n;
         pc_start_q  <= pc_start_n;
         frame_err_q <= frame_err_n;
         err_code_q  <= err_code_n;
      end
   end

   assign bus.wr_data   = wr_data_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.pc_start  = pc_start_q;
   assign bus.frame_err = frame_err_q;
   assign bus.err_code  = err_code_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_cfg_frame_parser.sv
// tb/tb_cfg_frame_parser.sv - scoreboard bench for cfg_frame_parser with frame-level reference model
module tb_cfg_frame_parser;

   localparam logic [7:0] HDR     = 8'hA5;
   localparam int          LEN_MAX = 160;
   localparam int          TMO     = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cfg_frame_parser_if bus ();

   cfg_frame_parser #(.HDR(HDR), .LEN_MAX(LEN_MAX), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         kind;   // 0 write, 1 pc_start, 2 frame_err
      logic [7:0] a;
      logic [7:0] d;
      logic [1:0] e;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
   endtask

   function automatic logic [7:0] wire_byte(input logic [7:0] b);
`ifdef CFG_BIT_REVERSE_EN
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
`else
      return b;
`endif
   endfunction

   function automatic void push_ev(input int k, input logic [7:0] a, input logic [7:0] d,
                                   input logic [1:0] e);
      ev_t x;
      x.kind = k; x.a = a; x.d = d; x.e = e;
      exp_q.push_back(x);
   endfunction

   // Reference model: a frame is HDR, length, payload, XOR of length and payload.
   // Returns how many bytes the line actually carries before a timeout (or all of them).
   function automatic int model_frame(input logic [7:0] b[$], input int g[$]);
      int         n;
      int         len;
      logic [7:0] x;
      n = b.size();
      for (int i = 1; i < b.size(); i++)
         if (g[i] > TMO) begin n = i; break; end
      if (n < 2) begin push_ev(2, 0, 0, 2'b11); return n; end
      len = b[1];
      if (len == 0 || len > LEN_MAX) begin push_ev(2, 0, 0, 2'b01); return 2; end
      x = b[1];
      for (int k = 0; k < len && 2 + k < n; k++) begin
         push_ev(0, 8'(k), b[2+k], 0);
         x ^= b[2+k];
      end
      if (2 + len < n) begin
         if (x == b[2+len]) push_ev(1, 0, 0, 0);
         else               push_ev(2, 0, 0, 2'b10);
      end else begin
         push_ev(2, 0, 0, 2'b11);
      end
      return n;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = wire_byte(b);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic run_frame(input string nm, input logic [7:0] b[$], input int g[$]);
      int n;
      n = model_frame(b, g);
      for (int i = 0; i < n; i++) send_byte(b[i], g[i]);
      if (n < b.size() || (n == 2 && b.size() > 2)) repeat (TMO + 5) @(negedge clk);
      else repeat (2) @(negedge clk);
      chk({nm, "_busy_after"}, bus.busy, 0);
   endtask

   // Monitor: every output event is matched against the head of the expected queue
   ev_t  mon_e;
   int   kind_act;
   logic prev_pc = 1'b0, prev_fe = 1'b0, prev_we = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wr_en || bus.pc_start || bus.frame_err) begin
            kind_act = bus.wr_en ? 0 : (bus.pc_start ? 1 : 2);
            if (exp_q.size() == 0) begin
               chk("spurious_event", 32'(kind_act) + 32'd16, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("event_kind", kind_act, mon_e.kind);
               if (mon_e.kind == 0) begin
                  chk("wr_addr", bus.wr_addr, mon_e.a);
                  chk("wr_data", bus.wr_data, mon_e.d);
               end
               if (mon_e.kind == 2) chk("err_code", bus.err_code, mon_e.e);
            end
            chk("pc_ferr_excl", bus.pc_start & bus.frame_err, 0);
         end
         if (prev_pc && bus.pc_start)  chk("pc_start_width", 1, 0);
         if (prev_fe && bus.frame_err) chk("frame_err_width", 1, 0);
      end
      prev_pc = bus.pc_start;
      prev_fe = bus.frame_err;
      prev_we = bus.wr_en;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired, %0d expected events pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic check_all_zero(input string nm);
      chk({nm, "_wr_en"},     bus.wr_en, 0);
      chk({nm, "_pc_start"},  bus.pc_start, 0);
      chk({nm, "_frame_err"}, bus.frame_err, 0);
      chk({nm, "_busy"},      bus.busy, 0);
      chk({nm, "_wr_addr"},   bus.wr_addr, 0);
      chk({nm, "_wr_data"},   bus.wr_data, 0);
      chk({nm, "_err_code"},  bus.err_code, 0);
   endtask

   initial begin
      logic [7:0] b[$];
      int         g[$];
      int         len, r;
      logic [7:0] x;

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      #1 rst = 1'b1;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Good frame
      b = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}; g = '{0, 0, 0, 0, 0, 0};
      run_frame("good", b, g);
      // Bad checksum
      b = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
      run_frame("badsum", b, g);
      // Bad lengths
      b = '{8'hA5, 8'h00}; g = '{0, 0};
      run_frame("len0", b, g);
      b = '{8'hA5, 8'hA1};
      run_frame("len161", b, g);
      // Timeout after one payload byte
      b = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h31}; g = '{0, 0, 0, TMO + 1, 0};
      run_frame("timeout", b, g);
      // Byte arriving exactly at the gap limit is accepted
      g = '{0, 0, 0, TMO, TMO};
      run_frame("gap_edge", b, g);
      // Header value inside payload/checksum is plain data
      b = '{8'hA5, 8'h01, 8'hA5, 8'h01 ^ 8'hA5}; g = '{0, 1, 0, 2};
      run_frame("hdr_in_data", b, g);

      // Reset after the second payload byte discards the frame silently
      push_ev(0, 8'h00, 8'h11, 0);
      push_ev(0, 8'h01, 8'h22, 0);
      send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all_zero("midreset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      b = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}; g = '{1, 0, 0, 0, 0, 0};
      run_frame("after_reset", b, g);

      // Randomized frames with idle garbage, random lengths, gaps and checksums
      for (int f = 0; f < 60; f++) begin
         repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 8'hA4)), $urandom_range(0, 2));
         r = $urandom_range(0, 9);
         if (r == 0)      len = 0;
         else if (r == 1) len = $urandom_range(LEN_MAX + 1, 255);
         else if (r == 2) len = LEN_MAX;
         else             len = $urandom_range(1, 8);
         b = '{HDR, 8'(len)};
         x = 8'(len);
         if (len >= 1 && len <= LEN_MAX) begin
            for (int k = 0; k < len; k++) begin
               b.push_back(8'($urandom));
               x ^= b[b.size()-1];
            end
            b.push_back(($urandom_range(0, 9) < 7) ? x : x ^ 8'($urandom_range(1, 255)));
         end
         g = {};
         foreach (b[i]) begin
            r = $urandom_range(0, 59);
            if (i > 0 && r == 0)      g.push_back(TMO + 1);
            else if (i > 0 && r < 4)  g.push_back(TMO);
            else                      g.push_back($urandom_range(0, 3));
         end
         run_frame("rand", b, g);
      end

      repeat (5) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cfg_frame_parser.md
CFG_FRAME_PARSER -- requirements
Module: cfg_frame_parser

Interface
REQ-001 Parameter HDR, default 8'hA5, frame header byte.
REQ-002 Parameter LEN_MAX, default 160, maximum payload length in bytes (16 channels x 10 bytes).
REQ-003 Parameter TIMEOUT, default 50000, maximum idle clk cycles between bytes inside a frame (1 ms at 50 MHz).
REQ-004 The block has one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rx_data  in  8  received UART byte.
REQ-008 rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-009 wr_data  out  8  payload byte to the channel RAM.
REQ-010 wr_addr  out  8  RAM write address.
REQ-011 wr_en  out  1  one-cycle RAM write strobe.
REQ-012 pc_start  out  1  one-cycle pulse when a frame is accepted; starts pulse generation.
REQ-013 frame_err  out  1  one-cycle pulse when a frame is rejected.
REQ-014 err_code  out  2  cause of last rejection (01 bad length, 10 bad checksum, 11 timeout); held until the next header.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, LEN, DATA and CHK.
REQ-017 IDLE: rx_valid with byte == HDR SHALL go to LEN, clear err_code, and clear the checksum and address registers; any other byte SHALL be ignored.
REQ-018 LEN: a length of 0 or >LEN_MAX SHALL pulse frame_err, set err_code=01, and return to IDLE; otherwise the length SHALL be latched, XORed into the checksum, and the FSM SHALL go to DATA.
REQ-019 DATA: each rx_valid SHALL produce wr_en=1 on the next cycle, with wr_data=byte and wr_addr=current index starting at 0.
REQ-020 DATA: each byte SHALL be XORed into the checksum, and the index SHALL increment by 1.
REQ-021 DATA: after the last (length-th) byte, the FSM SHALL go to CHK.
REQ-022 CHK: on rx_valid, the FSM SHALL compare the byte with the 8-bit XOR checksum and return to IDLE.
REQ-023 CHK match: pc_start SHALL pulse one cycle later.
REQ-024 CHK mismatch: frame_err SHALL pulse one cycle later and err_code SHALL be set to 10.
REQ-025 In LEN, DATA or CHK, a gap counter SHALL count cycles without rx_valid and reset on each rx_valid.
REQ-026 When the gap counter reaches TIMEOUT, frame_err SHALL pulse, err_code SHALL be set to 11, and the FSM SHALL go to IDLE.
REQ-027 If rx_valid coincides with the cycle the gap counter reaches TIMEOUT, the byte SHALL win: it is accepted and no timeout occurs.
REQ-028 RAM writes already issued for a rejected frame SHALL NOT be undone; only pc_start gates use of the data.
REQ-029 wr_en, pc_start and frame_err SHALL never be high for more than one consecutive cycle per event.
REQ-030 pc_start and frame_err SHALL be mutually exclusive.
REQ-031 wr_addr SHALL never exceed LEN_MAX-1, and the index SHALL not wrap within a frame.
REQ-032 A header byte received in DATA or CHK SHALL be treated as data or checksum, not as a resynchronisation.

Reset
REQ-033 rst SHALL force, asynchronously, the FSM to IDLE and all outputs to 0.
REQ-034 rst SHALL clear all internal counters and the checksum to 0.
REQ-035 Asserting rst mid-frame SHALL discard the partial frame with no frame_err and no pc_start.

Configuration
REQ-036 With macro CFG_BIT_REVERSE_EN defined, rx_data SHALL be bit-reversed (bit0<->bit7, etc.) before header compare, length decode, checksum and wr_data.
REQ-037 Without CFG_BIT_REVERSE_EN, rx_data SHALL be used unmodified.
REQ-038 Latency SHALL be identical with and without CFG_BIT_REVERSE_EN.

Verification
REQ-039 Bytes A5 03 11 22 33 03 -> wr_en x3 with (addr 0, 0x11), (addr 1, 0x22), (addr 2, 0x33), then pc_start one cycle after the checksum byte, and frame_err=0.
REQ-040 Bytes A5 03 11 22 33 04 -> three writes, then frame_err pulse, err_code=10, no pc_start, busy=0 afterwards.
REQ-041 Bytes A5 00, and separately A5 A1 (161 > LEN_MAX) -> frame_err, err_code=01, no wr_en.
REQ-042 Bytes A5 02 11, then no byte for TIMEOUT cycles -> frame_err, err_code=11, and IDLE; a byte arriving exactly at count TIMEOUT -> accepted, no error.
REQ-043 rst asserted after the second payload byte -> outputs 0 immediately; a following full valid frame -> writes from addr 0 and pc_start.
REQ-044 With CFG_BIT_REVERSE_EN: bytes A5 C0 88 44 CC C0 (the bit-reverses of the REQ-039 frame) -> the same writes and pc_start as REQ-039.
